mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences the shared multicycle MIPS datapath: one memory port, one ALU, the instruction register, the PC and the register file. It consumes the opcode/funct fields produced by the instruction decoder and the ALU Zero flag. It drives all mux selects and write enables, one state per datapath step, and stalls on a memory-ready handshake.

Parameters:
STATE_W, 4, width of state register and debug state output
ILLEGAL_STICKY, 1, 1 = illegal_instr holds until reset; 0 = one-cycle pulse

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
opcode  in  6  Instr[31:26] from decoder, valid while IR stable
funct  in  6  Instr[5:0] from decoder
Zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access this cycle
PCWrite  out  1  PC load enable
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
RegDst  out  1  write register: 0 = rt, 1 = rd
MemtoReg  out  1  write data: 0 = ALUOut, 1 = MDR
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 = PC, 1 = rs data
ALUSrcB  out  2  00 = rt data, 01 = const 4, 10 = sign-ext Imm, 11 = sign-ext Imm<<2
ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_instr  out  1  unsupported opcode/funct detected
state  out  STATE_W  current state (debug)

Behaviour:
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, next state = FETCH.
- State register updates on the rising CLK. With RST high at an edge: state <= FETCH, illegal_instr <= 0. Reset applies mid-instruction with no pending write completing.
- While RST is high, PCWrite, IRWrite, MemWrite, MemRead and RegWrite are forced to 0. All other outputs show FETCH values.
- Unlisted outputs are 0 in every state.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00. IRWrite and PCWrite equal mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=add (branch target precompute). Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEMADR
  - 000000 (R-type): EXEC
  - 000100 (beq): BRANCH
  - 001000 (addi): ADDIEX
  - 000010 (j): JUMP
  - any other opcode: FETCH, and set illegal_instr.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl from funct:
  - 100000 -> add
  - 100010 -> sub
  - 100100 -> and
  - 100101 -> or
  - 101010 -> slt
  - other funct: ALUControl=add, set illegal_instr, next state FETCH (no write).
  - Valid funct: next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=Zero. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state FETCH.
- Latency with mem_ready always 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- illegal_instr:
  - ILLEGAL_STICKY=1: stays high until RST.
  - ILLEGAL_STICKY=0: high for exactly the one cycle following detection.

Test Plan:
- Reset: RST=1 for 2 cycles mid-EXEC -> state=0. RegWrite, MemWrite, PCWrite and IRWrite are 0 during reset. After release, FETCH with MemRead=1.
- add (opcode 000000, funct 100000), mem_ready=1 -> states 0,1,6,7,0. ALUControl=010 in EXEC. RegWrite=1 and RegDst=1 only in ALUWB.
- lw with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. MemtoReg=1 and RegWrite=1 in MEMWB.
- beq: Zero=1 -> PCWrite=1 and PCSrc=01 in BRANCH. Zero=0 -> PCWrite=0. Both cases return to FETCH after 3 cycles.
- j (000010) -> PCSrc=10, PCWrite=1 in JUMP. sw with mem_ready=1 -> MemWrite=1 for exactly one cycle.
- opcode 111111 -> DECODE returns to FETCH and illegal_instr rises. It stays high across following instructions with ILLEGAL_STICKY=1, and pulses 1 cycle with ILLEGAL_STICKY=0. funct 000111 is handled the same way.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_if
// Brief    : Controller <-> datapath bundle for the multicycle MIPS control FSM
// Revision : 1.0  initial release
// ============================================================================
interface mips_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               Zero;
    logic               mem_ready;
    logic               PCWrite;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         ALUControl;
    logic [1:0]         PCSrc;
    logic               illegal_instr;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct, Zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal_instr, state
    );

    modport slave (
        output opcode, funct, Zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal_instr, state
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Brief    : Moore control FSM sequencing the shared multicycle MIPS datapath
// Revision : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int STATE_W        = 4,
    parameter bit ILLEGAL_STICKY = 1'b1
) (
    input  wire                    CLK,
    input  wire                    RST,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [STATE_W-1:0] c_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] c_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_MEMADR = STATE_W'(2);
    localparam logic [STATE_W-1:0] c_MEMRD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] c_MEMWB  = STATE_W'(4);
    localparam logic [STATE_W-1:0] c_MEMWR  = STATE_W'(5);
    localparam logic [STATE_W-1:0] c_EXEC   = STATE_W'(6);
    localparam logic [STATE_W-1:0] c_ALUWB  = STATE_W'(7);
    localparam logic [STATE_W-1:0] c_BRANCH = STATE_W'(8);
    localparam logic [STATE_W-1:0] c_ADDIEX = STATE_W'(9);
    localparam logic [STATE_W-1:0] c_ADDIWB = STATE_W'(10);
    localparam logic [STATE_W-1:0] c_JUMP   = STATE_W'(11);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    logic [STATE_W-1:0] state_q, state_d;
    logic               illegal_q, illegal_d;
    logic               w_funct_ok;
    logic [2:0]         w_exec_alu;
    logic               w_illegal_det;
    logic [STATE_W-1:0] w_out_st;

    always_comb begin
        w_funct_ok = 1'b1;
        w_exec_alu = c_ALU_ADD;
        case (bus.funct)
            6'b100000: w_exec_alu = c_ALU_ADD;
            6'b100010: w_exec_alu = c_ALU_SUB;
            6'b100100: w_exec_alu = c_ALU_AND;
            6'b100101: w_exec_alu = c_ALU_OR;
            6'b101010: w_exec_alu = c_ALU_SLT;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= c_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = c_FETCH;
        w_illegal_det = 1'b0;
        case (state_q)
            c_FETCH:  state_d = bus.mem_ready ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (bus.opcode)
                    c_OP_LW, c_OP_SW: state_d = c_MEMADR;
                    c_OP_RTYPE:       state_d = c_EXEC;
                    c_OP_BEQ:         state_d = c_BRANCH;
                    c_OP_ADDI:        state_d = c_ADDIEX;
                    c_OP_J:           state_d = c_JUMP;
                    default:          w_illegal_det = 1'b1;
                endcase
            end
            c_MEMADR: state_d = (bus.opcode == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:  state_d = bus.mem_ready ? c_MEMWB : c_MEMRD;
            c_MEMWR:  state_d = bus.mem_ready ? c_FETCH : c_MEMWR;
            c_EXEC: begin
                state_d       = w_funct_ok ? c_ALUWB : c_FETCH;
                w_illegal_det = !w_funct_ok;
            end
            c_ADDIEX: state_d = c_ADDIWB;
            default:  state_d = c_FETCH;
        endcase
    end

    generate
        if (ILLEGAL_STICKY) begin : g_illegal_sticky
            always_comb illegal_d = illegal_q | w_illegal_det;
        end else begin : g_illegal_pulse
            always_comb illegal_d = w_illegal_det;
        end
    endgenerate

    // Reset shows the FETCH decode; the write/request enables are masked below.
    assign w_out_st = RST ? c_FETCH : state_q;

    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 3'b000;
        bus.PCSrc      = 2'b00;
        case (w_out_st)
            c_FETCH: begin
                bus.MemRead    = 1'b1;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = c_ALU_ADD;
                bus.IRWrite    = bus.mem_ready;
                bus.PCWrite    = bus.mem_ready;
            end
            c_DECODE: begin
                bus.ALUSrcB    = 2'b11;
                bus.ALUControl = c_ALU_ADD;
            end
            c_MEMADR, c_ADDIEX: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = c_ALU_ADD;
            end
            c_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            c_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            c_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            c_EXEC: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = w_exec_alu;
            end
            c_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            c_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = c_ALU_SUB;
                bus.PCSrc      = 2'b01;
                bus.PCWrite    = bus.Zero;
            end
            c_ADDIWB: bus.RegWrite = 1'b1;
            c_JUMP: begin
                bus.PCSrc   = 2'b10;
                bus.PCWrite = 1'b1;
            end
            default: ;
        endcase
        if (RST) begin
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.MemRead  = 1'b0;
            bus.RegWrite = 1'b0;
        end
    end

    assign bus.state         = state_q;
    assign bus.illegal_instr = illegal_q;
endmodule
`default_nettype wire
